booth_mult_seq: RTL and testbench
=================================

Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. It is the successor to the team's fixed 4-bit combinational Booth step.
- Performs one add/subtract-and-arithmetic-shift step per clock over an internal register set, under a start/busy/done handshake.
- Supports signed and unsigned operands, selected per operation by a mode input.
- Sits beside the ALU as the multi-cycle multiply unit.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2. Product width is 2*WIDTH.
- N (localparam), WIDTH+1, internal extended operand width and the number of Booth iterations.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- multiplicand  in  WIDTH  operand M; captured with start
- multiplier  in  WIDTH  operand Q; captured with start
- busy  out  1  high from the cycle after an accepted start until done is asserted
- done  out  1  one-cycle pulse; product is valid from this cycle
- product  out  2*WIDTH  result; holds until the next completion

Behaviour:
- Reset (synchronous, active-high; rst has priority over all other inputs): state=IDLE, busy=0, done=0, product=0. All internal registers (A, Q, q_m1, M, count) are cleared.
- Operand extension:
  - Both operands are extended to N bits: sign-extended if signed_mode=1, zero-extended if 0.
  - After N steps the result is the 2N-bit value {A,Q}; product = its low 2*WIDTH bits. This is exact in both modes.
- States: IDLE, RUN, DONE.
- IDLE:
  - done=0, busy=0.
  - If start=1: load A=0, Q=ext(multiplier), q_m1=0, M=ext(multiplicand), count=N, and go to RUN.
  - Inputs are captured only at this edge; later input changes have no effect on the operation.
- RUN (busy=1): one Booth step per cycle, selected by {Q[0],q_m1}:
  - 00 or 11: no add.
  - 01: A = A + M.
  - 10: A = A - M, computed as A + ~M + 1.
  - Then arithmetic shift right of the N+N+1 chain {A,Q,q_m1}, replicating A's MSB.
  - The add/subtract is N bits wide, modulo 2^N; the carry out is discarded.
  - count decrements each step. On the step where count==1, product is registered from the post-shift value and state goes to DONE.
- DONE: done=1, busy=0, for exactly one cycle; then IDLE.
- Latency:
  - start sampled at edge 0; steps occur at edges 1..N; done is high in the cycle after edge N.
  - Throughput is one operation per N+2 cycles.
  - A start asserted during the DONE cycle is ignored. The earliest accepted restart is the first IDLE cycle.
- start while busy or in DONE: ignored, with no effect on the operation in progress.
- rst mid-RUN: the operation is aborted, outputs return to their reset values, and no done pulse is issued.
- Corner cases, all requiring an exact result:
  - Multiplicand or multiplier = 0.
  - Most-negative signed operand, e.g. -2^(WIDTH-1) × -2^(WIDTH-1).
  - All-ones unsigned operands.

Decomposition:
- Package booth_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Booth opcode constants: NOP, ADD, SUB, derived from {Q[0],q_m1}.
- Sub-module booth_radix2_step, parametrised on N. It is purely combinational:
  - Inputs: A, Q, q_m1, M.
  - Outputs: next A, Q, q_m1.
  - This is the parametrised generalisation of the existing 4-bit step.
- The top module holds the FSM, counter, operand extension and product register.

Test Plan:
- WIDTH=8, signed, -3 × 5 → done in the cycle after the 9th step edge; product=0xFFF1; busy high for exactly 9 cycles.
- WIDTH=8, unsigned, 255 × 255 → product=0xFE01. Same operands signed (-1 × -1) → product=0x0001.
- WIDTH=8, signed, -128 × -128 → product=0x4000. Unsigned 200 × 3 → product=0x0258.
- Start 7 × 6, then pulse start with new operands at steps 3 and in the DONE cycle → exactly one done pulse, product=0x002A; the second request is not accepted until IDLE.
- rst asserted at step 4 of 12 × 12 → next cycle busy=0, done=0, product=0, and no done pulse follows. A new start of 2 × 3 then gives product=0x0006.
- Random regression for WIDTH∈{4,8,16} in both modes → product equals the reference model's (sign- or zero-extended) product mod 2^(2·WIDTH); done is always exactly one cycle wide.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the Booth step opcode decoded from the two low bits of the Q chain.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    // {Q[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 leave A alone.
    function automatic booth_op_t decode_op(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// then arithmetic shift right of the {A, Q, q_m1} chain.
module booth_radix2_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N-1:0] m,
    output logic [N-1:0] a_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);

    localparam logic [N-1:0] ONE = N'(1);

    booth_op_t    op;
    logic [N-1:0] sum;

    assign op = decode_op(q[0], q_m1);

    // Arithmetic is modulo 2^N; the carry out is intentionally dropped.
    always_comb begin
        sum = a;
        case (op)
            ADD:     sum = a + m;
            SUB:     sum = a + ~m + ONE;
            default: sum = a;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_shift
            assign a_next[gi] = sum[gi+1];
            assign q_next[gi] = q[gi+1];
        end
    endgenerate

    assign a_next[N-1] = sum[N-1];
    assign q_next[N-1] = sum[0];
    assign q_m1_next   = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over N=WIDTH+1
// bit extended operands, giving exact signed or unsigned 2*WIDTH-bit products.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] COUNT_INIT = CW'(N);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_t           state_reg, state_next;
    logic [N-1:0]     a_reg, a_next;
    logic [N-1:0]     q_reg, q_next;
    logic             q_m1_reg, q_m1_next;
    logic [N-1:0]     m_reg, m_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    logic [N-1:0]     mc_ext, mp_ext;
    logic [N-1:0]     a_step, q_step;
    logic             q_m1_step;
    logic [2*N-1:0]   chain_step;

    // The extra top bit lets unsigned operands ride through signed Booth
    // arithmetic as non-negative values, so both modes are exact.
    assign mc_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign mp_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

    booth_radix2_step #(
        .N (N)
    ) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

    assign chain_step = {a_step, q_step};

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        q_m1_next    = q_m1_reg;
        m_next       = m_reg;
        count_next   = count_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = '0;
                    q_next     = mp_ext;
                    q_m1_next  = 1'b0;
                    m_next     = mc_ext;
                    count_next = COUNT_INIT;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next     = a_step;
                q_next     = q_step;
                q_m1_next  = q_m1_step;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    product_next = chain_step[2*WIDTH-1:0];
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            m_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            q_m1_reg    <= q_m1_next;
            m_reg       <= m_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq at WIDTH 4, 8 and 16: products,
// latency, handshake filtering and mid-operation reset.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    logic        op_mode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        start4, start8, start16;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;
    logic [7:0]  product4;
    logic [15:0] product8;
    logic [31:0] product16;

    int          sel;
    logic        cur_busy;
    logic        cur_done;
    logic [31:0] cur_prod;

    int pass_count  = 0;
    int check_count = 0;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(op_mode),
        .multiplicand(op_a[3:0]), .multiplier(op_b[3:0]),
        .busy(busy4), .done(done4), .product(product4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(op_mode),
        .multiplicand(op_a[7:0]), .multiplier(op_b[7:0]),
        .busy(busy8), .done(done8), .product(product8)
    );

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(op_mode),
        .multiplicand(op_a), .multiplier(op_b),
        .busy(busy16), .done(done16), .product(product16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        cur_busy = busy8;
        cur_done = done8;
        cur_prod = 32'(product8);
        case (sel)
            4: begin
                cur_busy = busy4;
                cur_done = done4;
                cur_prod = 32'(product4);
            end
            16: begin
                cur_busy = busy16;
                cur_done = done16;
                cur_prod = product16;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic set_start(input int w, input logic v);
        start4  = (w == 4)  ? v : 1'b0;
        start8  = (w == 8)  ? v : 1'b0;
        start16 = (w == 16) ? v : 1'b0;
    endtask

    // One full operation: latency, busy width, product, done width, hold.
    task automatic run_op(input string tag, input int w, input logic sm,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        int cyc;
        int busy_cycles;
        sel = w;
        @(negedge clk);
        op_mode = sm;
        op_a    = a;
        op_b    = b;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        op_mode = ~sm;
        op_a    = ~a;
        op_b    = a ^ b ^ 16'h5a5a;
        cyc = 1;
        busy_cycles = 0;
        while (!cur_done && cyc < 64) begin
            if (cur_busy) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(w + 2));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(w + 1));
        check({tag, "_product"}, cur_prod, exp);
        $display("op %s w=%0d signed=%0d a=0x%0h b=0x%0h product=0x%0h cycles=%0d",
                 tag, w, sm, a, b, cur_prod, cyc);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(cur_done), 32'd0);
        check({tag, "_hold"}, cur_prod, exp);
    endtask

    initial begin
        int dones;
        int done_cyc;
        logic busy_after;

        rst = 1'b1;
        op_mode = 1'b0;
        op_a = '0;
        op_b = '0;
        sel = 8;
        set_start(0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_product", 32'(product8), 32'd0);
        rst = 1'b0;

        run_op("s_m3x5",      8, 1'b1, 16'h00FD, 16'h0005, 32'h0000_FFF1);
        run_op("u_255x255",   8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01);
        run_op("s_m1xm1",     8, 1'b1, 16'h00FF, 16'h00FF, 32'h0000_0001);
        run_op("s_m128xm128", 8, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000);
        run_op("u_200x3",     8, 1'b0, 16'h00C8, 16'h0003, 32'h0000_0258);
        run_op("s_0xm77",     8, 1'b1, 16'h0000, 16'h00B3, 32'h0000_0000);
        run_op("s_127xm128",  8, 1'b1, 16'h007F, 16'h0080, 32'h0000_C080);
        run_op("u_255x128",   8, 1'b0, 16'h00FF, 16'h0080, 32'h0000_7F80);
        run_op("u_255x0",     8, 1'b0, 16'h00FF, 16'h0000, 32'h0000_0000);

        run_op("w4_s_m8xm8",  4, 1'b1, 16'h0008, 16'h0008, 32'h0000_0040);
        run_op("w4_u_15x15",  4, 1'b0, 16'h000F, 16'h000F, 32'h0000_00E1);
        run_op("w4_s_7xm8",   4, 1'b1, 16'h0007, 16'h0008, 32'h0000_00C8);
        run_op("w4_s_m1x1",   4, 1'b1, 16'h000F, 16'h0001, 32'h0000_00FF);

        run_op("w16_s_min",   16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        run_op("w16_u_ones",  16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("w16_s_mix",   16, 1'b1, 16'h04D2, 16'hFFFE, 32'hFFFF_F65C);
        run_op("w16_u_zero",  16, 1'b0, 16'h1234, 16'h0000, 32'h0000_0000);

        // Starts during RUN and during DONE must both be ignored.
        sel = 8;
        @(negedge clk);
        op_mode = 1'b0;
        op_a = 16'd7;
        op_b = 16'd6;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        done_cyc = 0;
        busy_after = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            if (done8) begin
                dones++;
                done_cyc = c;
            end
            if (done_cyc != 0 && c == done_cyc + 1) busy_after = busy8;
            start8 = (c == 3) || done8;
            if (c == 3) begin
                op_a = 16'd9;
                op_b = 16'd9;
            end else if (done8) begin
                op_a = 16'd5;
                op_b = 16'd5;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        $display("op handshake 7x6 dones=%0d done_cyc=%0d product=0x%0h", dones, done_cyc, product8);
        check("hs_done_pulses", 32'(dones), 32'd1);
        check("hs_done_cycle", 32'(done_cyc), 32'd10);
        check("hs_product", 32'(product8), 32'h002A);
        check("hs_restart_ignored", 32'(busy_after), 32'd0);

        // Reset in the middle of 12 x 12 aborts without a done pulse.
        @(negedge clk);
        op_mode = 1'b0;
        op_a = 16'd12;
        op_b = 16'd12;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_running", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_product", 32'(product8), 32'd0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done8) dones++;
            @(negedge clk);
        end
        $display("op abort 12x12 dones_after_reset=%0d", dones);
        check("abort_no_done", 32'(dones), 32'd0);
        run_op("after_abort_2x3", 8, 1'b0, 16'd2, 16'd3, 32'h0000_0006);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
